ahb_slave_mem: RTL and testbench
================================

# ahb_slave_mem

AHB-Lite slave memory for the bus driven by the EFLX AHB master wrapper: it terminates the master's HADDR/HTRANS/HWRITE/HWDATA transfers, stores 32-bit words in an internal array and returns HRDATA/HREADY/HRESP. Programmable wait states let the master's stall paths be exercised in closed loop. Out-of-region addresses and non-word sizes get a two-cycle ERROR response. It sits directly downstream of the master wrapper and replaces the hand-driven HREADY/HRDATA stimulus on the bus.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width (word = DATA_WIDTH bits; only 32 supported)
- MEM_WORDS_LOG2, 8, log2 of memory depth in words (256 words = 1 KiB)
- BASE_ADDR, 32'hA0000000, region base; must be aligned to 4*2^MEM_WORDS_LOG2
- WAIT_STATES, 0, wait cycles inserted per OKAY data phase, 0..7

- HCLK  in  1  bus clock, all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  ADDR_WIDTH  byte address
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size; only 3'b010 legal
- HBURST  in  3  accepted, not decoded (each beat handled independently)
- HWDATA  in  DATA_WIDTH  write data, valid in data phase
- HREADY  in  1  bus-level ready (HREADYOUT fed back in single-slave systems)
- HRDATA  out  DATA_WIDTH  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  2  00 OKAY, 01 ERROR; 10/11 never driven
- err_cnt  out  8  saturating count of ERROR responses

## Operation
- Address phase sampled on an edge where HSEL & HREADY & HTRANS[1]; capture HWRITE, word index HADDR[MEM_WORDS_LOG2+1:2], error flag.
- Error flag = HSIZE != 3'b010, or HADDR[1:0] != 0, or HADDR[ADDR_WIDTH-1:MEM_WORDS_LOG2+2] != BASE_ADDR same bits.
- IDLE/BUSY or HSEL=0: no transfer; next cycle is zero-wait OKAY.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=OKAY. Valid sample with error -> ERR1; valid OKAY sample with WAIT_STATES>0 -> WAIT (counter = WAIT_STATES-1); WAIT_STATES=0 -> stay IDLE (data phase completes next cycle).
  - WAIT: HREADYOUT=0, HRESP=OKAY; counter decrements; at 0 -> IDLE (final data-phase cycle with HREADYOUT=1).
  - ERR1: HREADYOUT=0, HRESP=ERROR -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR; may sample new address phase (same rules as IDLE).
- Write commits mem[idx] <= HWDATA on the edge ending the final OKAY data-phase cycle. Errored writes never touch memory.
- Read: HRDATA register loads mem[idx] on the edge entering the final data-phase cycle (W=0: the address-sampling edge, indexed from HADDR directly; W>0: edge leaving last WAIT cycle, from captured index). Errored reads hold HRDATA.
- Forwarding: if a write commits on the same edge HRDATA loads and indices match, HRDATA loads HWDATA.
- err_cnt increments on entry to ERR1; saturates at 255.
- Memory contents not reset; undefined until written.

## Timing
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, err_cnt=0, FSM=IDLE, wait counter=0.
- Reset mid-transfer: dominates every other event; FSM->IDLE next edge, pending write dropped, in-flight read returns nothing.
- OKAY latency: address edge E0; HREADYOUT low in cycles E0..E0+W-1 (W=WAIT_STATES), high in cycle after E0+W; write commits at edge E0+W+1.
- ERROR: exactly two data-phase cycles, HREADYOUT 0 then 1, HRESP=01 in both.
- Pipelined back-to-back NONSEQ/SEQ at W=0: one transfer per cycle, no bubbles.
- Address phases presented while HREADY=0 are ignored (master must hold them).
- Index wraps only by truncation; any address outside the region is ERROR, never aliased.

## Test plan
- W=0: write 0x11111111 to 0xA0000000, then read 0xA0000000 back-to-back -> HREADYOUT stays 1, HRDATA=0x11111111 via forwarding, HRESP=00.
- W=3: write 0xDEADBEEF to 0xA0000010 -> HREADYOUT low exactly 3 cycles; subsequent read returns 0xDEADBEEF after 3 wait cycles.
- INCR burst of 8 SEQ writes from 0xA0000020, data 1..8, W=0, then 8-beat read -> HRDATA 1..8 in consecutive cycles.
- Write to 0xB0000000 -> HRESP=01 for 2 cycles, HREADYOUT 0 then 1, err_cnt=1; memory unchanged; HSIZE=3'b000 access -> err_cnt=2.
- IDLE and BUSY with HSEL=1 -> HREADYOUT=1, HRESP=00, no memory or HRDATA change.
- Assert HRESET during W=3 write wait -> next cycle HREADYOUT=1, HRESP=00, HRDATA=0, err_cnt=0; target word not written.

Source files
------------

// File: rtl/ahb_slave_mem_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_mem_if
// AHB-Lite bus bundle between the EFLX AHB master wrapper and the slave
// memory. Clock and reset are not part of the bundle; they are wired as plain
// ports on the slave.
//
// Signals:
//   HSEL      slave select
//   HADDR     byte address (address phase)
//   HTRANS    transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   HWRITE    1 = write
//   HSIZE     transfer size, only 3'b010 (word) is legal
//   HBURST    burst type, carried but not decoded by the slave
//   HWDATA    write data (data phase)
//   HREADY    bus-level ready seen by the slave
//   HRDATA    read data from the slave
//   HREADYOUT slave ready
//   HRESP     00 OKAY, 01 ERROR
// ---------------------------------------------------------------------------
interface ahb_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic [1:0]            HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HREADY, HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// ahb_slave_mem
// AHB-Lite slave memory. Terminates word transfers into an internal array of
// 2^MEM_WORDS_LOG2 32-bit words located at BASE_ADDR, inserts WAIT_STATES
// wait cycles per OKAY data phase and answers illegal accesses (outside the
// region, misaligned, or not word-sized) with a two-cycle ERROR response.
//
// Ports:
//   HCLK     bus clock, all logic on the rising edge
//   HRESET   synchronous active-high reset
//   bus      AHB-Lite slave modport (see ahb_slave_mem_if)
//   err_cnt  saturating count of ERROR responses issued
// ---------------------------------------------------------------------------
module ahb_slave_mem #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    MEM_WORDS_LOG2 = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'hA0000000,
    parameter int                    WAIT_STATES    = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    ahb_slave_mem_if.slave         bus,
    output logic [7:0]             err_cnt
);

    localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;
    localparam int TAG_LSB   = MEM_WORDS_LOG2 + 2;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                waitCnt_q, waitCnt_d;
    logic                      pending_q, pending_d;
    logic                      write_q, write_d;
    logic [MEM_WORDS_LOG2-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0]     hrdata_q;
    logic [7:0]                errCnt_q;

    logic [DATA_WIDTH-1:0]     mem [MEM_WORDS];

    logic                      sample;
    logic                      addrErr;
    logic [MEM_WORDS_LOG2-1:0] addrIdx;
    logic                      commit;
    logic                      rdLoad;
    logic [MEM_WORDS_LOG2-1:0] rdIdx;
    logic                      hreadyout;
    logic [1:0]                hresp;
    logic                      unusedBits;

    // Burst type and the SEQ/NONSEQ distinction do not matter here: every
    // beat is decoded on its own.
    assign unusedBits = ^{bus.HBURST, bus.HTRANS[0]};

    // Address phases are only taken while this slave is driving ready high
    // (IDLE or the second ERROR cycle); in the stall states the master is
    // required to hold its address, so sampling is suppressed there.
    assign sample  = bus.HSEL && bus.HREADY && bus.HTRANS[1]
                     && ((state_q == S_IDLE) || (state_q == S_ERR2));
    assign addrIdx = bus.HADDR[TAG_LSB-1:2];
    assign addrErr = (bus.HSIZE != 3'b010)
                     || (bus.HADDR[1:0] != 2'b00)
                     || (bus.HADDR[ADDR_WIDTH-1:TAG_LSB] != BASE_ADDR[ADDR_WIDTH-1:TAG_LSB]);

    // An OKAY transfer is in its final data-phase cycle whenever one is
    // pending and the FSM is back in IDLE; the write lands on the edge
    // closing that cycle.
    assign commit = pending_q && write_q && (state_q == S_IDLE);

    // Next-state and output decode. The read-data load is decided here so
    // that it happens on the edge entering the final data-phase cycle.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        pending_d = pending_q;
        write_d   = write_q;
        idx_d     = idx_q;
        rdLoad    = 1'b0;
        rdIdx     = idx_q;
        hreadyout = 1'b1;
        hresp     = RESP_OKAY;

        case (state_q)
            S_IDLE, S_ERR2: begin
                hreadyout = 1'b1;
                hresp     = (state_q == S_ERR2) ? RESP_ERROR : RESP_OKAY;
                state_d   = S_IDLE;
                pending_d = 1'b0;
                if (sample) begin
                    write_d = bus.HWRITE;
                    idx_d   = addrIdx;
                    if (addrErr) begin
                        state_d = S_ERR1;
                    end else begin
                        pending_d = 1'b1;
                        if (WAIT_STATES == 0) begin
                            state_d = S_IDLE;
                            if (!bus.HWRITE) begin
                                rdLoad = 1'b1;
                                rdIdx  = addrIdx;
                            end
                        end else begin
                            state_d   = S_WAIT;
                            waitCnt_d = 3'(WAIT_STATES - 1);
                        end
                    end
                end
            end
            S_WAIT: begin
                hreadyout = 1'b0;
                if (waitCnt_q == 3'd0) begin
                    state_d = S_IDLE;
                    if (!write_q) begin
                        rdLoad = 1'b1;
                        rdIdx  = idx_q;
                    end
                end else begin
                    waitCnt_d = waitCnt_q - 3'd1;
                end
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = RESP_ERROR;
                state_d   = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers. Reset wins over everything, which also drops any
    // write still waiting to commit.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= S_IDLE;
            waitCnt_q <= 3'd0;
            pending_q <= 1'b0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            hrdata_q  <= '0;
            errCnt_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            pending_q <= pending_d;
            write_q   <= write_d;
            idx_q     <= idx_d;
            if (rdLoad) begin
                // A back-to-back write to the same word has not reached the
                // array yet, so its data is taken straight from the bus.
                if (commit && (idx_q == rdIdx)) begin
                    hrdata_q <= bus.HWDATA;
                end else begin
                    hrdata_q <= mem[rdIdx];
                end
            end
            if ((state_d == S_ERR1) && (state_q != S_ERR1) && (errCnt_q != 8'hFF)) begin
                errCnt_q <= errCnt_q + 8'd1;
            end
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge HCLK) begin
        if (!HRESET && commit) begin
            mem[idx_q] <= bus.HWDATA;
        end
    end

    assign bus.HRDATA    = hrdata_q;
    assign bus.HREADYOUT = hreadyout;
    assign bus.HRESP     = hresp;
    assign err_cnt       = errCnt_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_mem
// Two slave instances share one bench: dut0 with no wait states and dut1
// with three. Each has its own bus, reset and expected-response queue; a
// word-array model decides what every transfer should return.
// ---------------------------------------------------------------------------
module tb_ahb_slave_mem;

    localparam logic [31:0] BASE = 32'hA0000000;
    localparam int          WS [2] = '{0, 3};

    typedef struct packed {
        logic        isErr;
        logic        isWrite;
        logic        known;
        logic [31:0] data;
    } exp_t;

    logic        HCLK;
    logic        rst    [2];
    logic        hsel   [2];
    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [2:0]  hburst [2];
    logic [31:0] hwdata [2];
    logic [7:0]  errCnt0, errCnt1;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] modelMem   [2][256];
    bit          modelKnown [2][256];
    int          errExp [2];
    logic [31:0] lastRd [2];

    bit          inDP   [2];
    int          lowCnt [2];
    bit          lowBad [2];

    int testsRun    = 0;
    int testsFailed = 0;

    ahb_slave_mem_if bus0();
    ahb_slave_mem_if bus1();

    assign bus0.HSEL   = hsel[0];
    assign bus0.HADDR  = haddr[0];
    assign bus0.HTRANS = htrans[0];
    assign bus0.HWRITE = hwrite[0];
    assign bus0.HSIZE  = hsize[0];
    assign bus0.HBURST = hburst[0];
    assign bus0.HWDATA = hwdata[0];
    assign bus0.HREADY = bus0.HREADYOUT;

    assign bus1.HSEL   = hsel[1];
    assign bus1.HADDR  = haddr[1];
    assign bus1.HTRANS = htrans[1];
    assign bus1.HWRITE = hwrite[1];
    assign bus1.HSIZE  = hsize[1];
    assign bus1.HBURST = hburst[1];
    assign bus1.HWDATA = hwdata[1];
    assign bus1.HREADY = bus1.HREADYOUT;

    ahb_slave_mem #(.WAIT_STATES(0)) dut0 (
        .HCLK   (HCLK),
        .HRESET (rst[0]),
        .bus    (bus0),
        .err_cnt(errCnt0)
    );

    ahb_slave_mem #(.WAIT_STATES(3)) dut1 (
        .HCLK   (HCLK),
        .HRESET (rst[1]),
        .bus    (bus1),
        .err_cnt(errCnt1)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Single comparison point: counts every check and reports a miss.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void pushExp(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic int qSize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t peekExp(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    function automatic exp_t popExp(input int k);
        return (k == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    function automatic logic readyOf(input int k);
        return (k == 0) ? bus0.HREADYOUT : bus1.HREADYOUT;
    endfunction

    // Issue one address phase, hold it until accepted, then present the
    // write data for its data phase. With track set, the model is updated
    // and the expected response queued.
    task automatic applyStimulus(input int k, input logic [31:0] addr, input logic wr,
                                 input logic [2:0] size, input logic [31:0] wdata,
                                 input logic [1:0] trans, input bit track);
        exp_t e;
        bit   err;
        int   idx;
        int   guard;
        logic rdy;
        err = (size != 3'b010) || (addr % 4 != 0) || (addr < BASE) || (addr >= BASE + 32'd1024);
        idx = int'((addr - BASE) / 4) & 255;
        if (track) begin
            e.isErr   = err;
            e.isWrite = wr;
            e.known   = 1'b0;
            e.data    = 32'd0;
            if (err) begin
                if (errExp[k] < 255) errExp[k]++;
            end else if (wr) begin
                modelMem[k][idx]   = wdata;
                modelKnown[k][idx] = 1'b1;
            end else begin
                e.known   = modelKnown[k][idx];
                e.data    = modelMem[k][idx];
                lastRd[k] = modelMem[k][idx];
            end
            pushExp(k, e);
        end
        hsel[k]   = 1'b1;
        haddr[k]  = addr;
        htrans[k] = trans;
        hwrite[k] = wr;
        hsize[k]  = size;
        hburst[k] = 3'($urandom_range(0, 7));
        guard = 0;
        do begin
            @(negedge HCLK);
            rdy = readyOf(k);
            @(posedge HCLK);
            #1;
            guard++;
        end while (!rdy && guard < 50);
        if (!rdy) checkOutput("acceptTimeout", 32'd1, 32'd0);
        hwdata[k] = wr ? wdata : $urandom;
    endtask

    task automatic idleCycles(input int k, input int n, input logic sel, input logic [1:0] trans);
        hsel[k]   = sel;
        htrans[k] = trans;
        haddr[k]  = $urandom;
        hwrite[k] = 1'($urandom_range(0, 1));
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic drain(input int k);
        int guard;
        hsel[k]   = 1'b0;
        htrans[k] = 2'b00;
        guard = 0;
        while ((qSize(k) != 0 || inDP[k]) && guard < 100) begin
            @(posedge HCLK);
            #1;
            guard++;
        end
        if (guard >= 100) checkOutput("drainTimeout", 32'd1, 32'd0);
        @(posedge HCLK);
        #1;
    endtask

    task automatic randomTraffic(input int k, input int n);
        logic [31:0] addr;
        int          r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 80)      addr = BASE + 32'($urandom_range(0, 31)) * 4;
            else if (r < 88) addr = BASE + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
            else             addr = $urandom;
            applyStimulus(k, addr, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010,
                          $urandom, 2'($urandom_range(2, 3)), 1'b1);
            r = $urandom_range(0, 7);
            if (r == 0)      idleCycles(k, 1, 1'b1, 2'($urandom_range(0, 1)));
            else if (r == 1) idleCycles(k, 1, 1'b0, 2'b10);
        end
        drain(k);
        checkOutput($sformatf("errCnt%0d", k), (k == 0) ? 32'(errCnt0) : 32'(errCnt1), 32'(errExp[k]));
    endtask

    // Monitor: follows each accepted address phase into its data phase,
    // counts stall cycles and compares the completing cycle with the queue.
    always @(negedge HCLK) begin
        for (int k = 0; k < 2; k++) begin
            logic        ro;
            logic [1:0]  rr;
            logic [31:0] rd;
            logic        s;
            exp_t        e;
            ro = (k == 0) ? bus0.HREADYOUT : bus1.HREADYOUT;
            rr = (k == 0) ? bus0.HRESP     : bus1.HRESP;
            rd = (k == 0) ? bus0.HRDATA    : bus1.HRDATA;
            s  = hsel[k] && ro && htrans[k][1];
            if (rst[k]) begin
                inDP[k] = 1'b0;
            end else begin
                if (inDP[k]) begin
                    if (!ro) begin
                        lowCnt[k]++;
                        if (qSize(k) != 0) begin
                            e = peekExp(k);
                            if (rr != (e.isErr ? 2'b01 : 2'b00)) lowBad[k] = 1'b1;
                        end
                    end else begin
                        inDP[k] = 1'b0;
                        if (qSize(k) == 0) begin
                            checkOutput($sformatf("unexpectedPhase%0d", k), 32'd1, 32'd0);
                        end else begin
                            e = popExp(k);
                            checkOutput($sformatf("hresp%0d", k), 32'(rr), e.isErr ? 32'd1 : 32'd0);
                            checkOutput($sformatf("waitCycles%0d", k), 32'(lowCnt[k]),
                                        e.isErr ? 32'd1 : 32'(WS[k]));
                            if (lowCnt[k] != 0)
                                checkOutput($sformatf("stallResp%0d", k), 32'(lowBad[k]), 32'd0);
                            if (!e.isErr && !e.isWrite && e.known)
                                checkOutput($sformatf("hrdata%0d", k), rd, e.data);
                        end
                    end
                end
                if (s) begin
                    inDP[k]   = 1'b1;
                    lowCnt[k] = 0;
                    lowBad[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k]    = 1'b1;
            hsel[k]   = 1'b0;
            haddr[k]  = 32'd0;
            htrans[k] = 2'b00;
            hwrite[k] = 1'b0;
            hsize[k]  = 3'b010;
            hburst[k] = 3'b000;
            hwdata[k] = 32'd0;
            errExp[k] = 0;
            lastRd[k] = 32'd0;
            inDP[k]   = 1'b0;
            lowCnt[k] = 0;
            lowBad[k] = 1'b0;
        end
        repeat (3) @(posedge HCLK);
        #1;
        checkOutput("rstReady0", 32'(bus0.HREADYOUT), 32'd1);
        checkOutput("rstResp0",  32'(bus0.HRESP),     32'd0);
        checkOutput("rstRdata0", bus0.HRDATA,          32'd0);
        checkOutput("rstErr0",   32'(errCnt0),         32'd0);
        checkOutput("rstReady1", 32'(bus1.HREADYOUT), 32'd1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Zero-wait write then read of the same word (forwarding path).
        applyStimulus(0, BASE, 1'b1, 3'b010, 32'h11111111, 2'b10, 1'b1);
        applyStimulus(0, BASE, 1'b0, 3'b010, 32'h0,        2'b10, 1'b1);
        drain(0);

        // IDLE and BUSY with the slave selected must leave everything alone.
        for (int i = 0; i < 6; i++) begin
            idleCycles(0, 1, 1'b1, (i % 2 == 0) ? 2'b00 : 2'b01);
            checkOutput("idleReady", 32'(bus0.HREADYOUT), 32'd1);
            checkOutput("idleResp",  32'(bus0.HRESP),     32'd0);
            checkOutput("idleRdata", bus0.HRDATA,          lastRd[0]);
        end

        // Eight-beat incrementing burst written then read back.
        for (int i = 0; i < 8; i++)
            applyStimulus(0, BASE + 32'h20 + 32'(i) * 4, 1'b1, 3'b010, 32'(i + 1),
                          (i == 0) ? 2'b10 : 2'b11, 1'b1);
        for (int i = 0; i < 8; i++)
            applyStimulus(0, BASE + 32'h20 + 32'(i) * 4, 1'b0, 3'b010, 32'h0,
                          (i == 0) ? 2'b10 : 2'b11, 1'b1);
        drain(0);

        // Out-of-region write whose low bits alias word 0, then a byte read.
        applyStimulus(0, 32'hB0000000, 1'b1, 3'b010, 32'h55555555, 2'b10, 1'b1);
        drain(0);
        checkOutput("errCntRegion", 32'(errCnt0), 32'd1);
        applyStimulus(0, BASE, 1'b0, 3'b000, 32'h0, 2'b10, 1'b1);
        drain(0);
        checkOutput("errCntSize", 32'(errCnt0), 32'd2);
        applyStimulus(0, BASE, 1'b0, 3'b010, 32'h0, 2'b10, 1'b1);
        drain(0);

        // Three-wait-state instance: write, read back, one error.
        applyStimulus(1, BASE + 32'h10, 1'b1, 3'b010, 32'hDEADBEEF, 2'b10, 1'b1);
        applyStimulus(1, BASE + 32'h10, 1'b0, 3'b010, 32'h0,        2'b10, 1'b1);
        applyStimulus(1, 32'hA0000402,  1'b1, 3'b010, 32'h77777777, 2'b10, 1'b1);
        applyStimulus(1, BASE + 32'h20, 1'b1, 3'b010, 32'h0BADF00D, 2'b10, 1'b1);
        drain(1);
        checkOutput("errCnt1pre", 32'(errCnt1), 32'd1);

        // Reset arriving while a write is stalled in its wait states.
        applyStimulus(1, BASE + 32'h20, 1'b1, 3'b010, 32'hCAFEF00D, 2'b10, 1'b0);
        hsel[1]   = 1'b0;
        htrans[1] = 2'b00;
        rst[1]    = 1'b1;
        @(posedge HCLK);
        #1;
        checkOutput("midRstReady", 32'(bus1.HREADYOUT), 32'd1);
        checkOutput("midRstResp",  32'(bus1.HRESP),     32'd0);
        checkOutput("midRstRdata", bus1.HRDATA,          32'd0);
        checkOutput("midRstErr",   32'(errCnt1),         32'd0);
        rst[1]    = 1'b0;
        errExp[1] = 0;
        lastRd[1] = 32'd0;
        applyStimulus(1, BASE + 32'h20, 1'b0, 3'b010, 32'h0, 2'b10, 1'b1);
        drain(1);

        randomTraffic(0, 150);
        randomTraffic(1, 80);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
